pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the IF / IF-ID / ID / EX datapath. It watches the decode outputs (register addresses, opcode, funct3, decode error) and the EX-stage status (load destination, jump request, multi-cycle busy). It generates the hold, flush and redirect controls for the PC and the IF-ID and ID-EX pipeline registers. It also sequences illegal-instruction traps through a request/acknowledge handshake, and counts lost cycles.

## Interface
Parameters:
- FLUSH_CYCLES, 1, bubble cycles inserted after any redirect (1..4; covers fetch latency).
- CNT_WIDTH, 16, width of the saturating stall counter.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid_i  in  1  ID stage holds a real (non-bubble) instruction.
- id_pc_i  in  32  PC of the ID instruction.
- id_opcode_i  in  7  decoded opcode.
- id_funct3_i  in  3  decoded funct3.
- id_rs1_addr_i / id_rs2_addr_i  in  5  decoded source registers.
- id_err_i  in  1  decode error for the ID instruction.
- ex_is_load_i  in  1  EX holds a load.
- ex_rd_addr_i  in  5  EX destination register.
- ex_jump_i  in  1  EX resolved a taken branch/jump.
- ex_jump_addr_i  in  32  jump target.
- ex_busy_i  in  1  EX multi-cycle op in progress.
- mtvec_i  in  32  trap vector.
- trap_ack_i  in  1  trap accepted by CSR unit.
- pc_hold_o  out  1  freeze PC.
- if_id_hold_o  out  1  freeze IF-ID register.
- if_id_flush_o  out  1  load bubble into IF-ID.
- id_ex_hold_o  out  1  freeze ID-EX register.
- id_ex_flush_o  out  1  load bubble into ID-EX.
- pc_jump_o  out  1  redirect PC this cycle.
- pc_jump_addr_o  out  32  redirect target.
- trap_req_o  out  1  registered trap request.
- trap_pc_o  out  32  registered faulting PC.
- stall_cnt_o  out  CNT_WIDTH  lost-cycle count.
- stall_cnt_clr_i  in  1  synchronous counter clear.

## Operation
- States: RUN, FLUSH, TRAP.
- rs1 is used by opcodes 0010011, 0000011, 0100011, 0110011, 1100111, 1100011, and 1110011 with funct3[2]=0.
- rs2 is used by opcodes 0100011, 0110011, 1100011.
- Load-use hazard = id_valid_i & ex_is_load_i & ex_rd_addr_i!=0 & (used rs1==ex_rd_addr_i or used rs2==ex_rd_addr_i).
- RUN priority, highest first:
  1. ex_jump_i: pc_jump_o=1, addr=ex_jump_addr_i, if_id_flush_o=1, id_ex_flush_o=1. Go to FLUSH with count=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else stay in RUN.
  2. ex_busy_i: pc_hold_o, if_id_hold_o and id_ex_hold_o all 1. A pending error or hazard waits.
  3. id_valid_i & id_err_i: pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1. Latch trap_pc_o=id_pc_i and go to TRAP.
  4. Load-use hazard: pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1 for one cycle; stay in RUN.
  5. Otherwise all controls are 0.
- FLUSH:
  - if_id_flush_o=1 and id_ex_flush_o=1 every cycle; count decrements and the block returns to RUN when count=0.
  - ex_jump_i in FLUSH restarts the redirect exactly as from RUN.
- TRAP:
  - trap_req_o=1; pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1 until trap_ack_i.
  - Cycle with trap_ack_i=1: pc_jump_o=1, addr=mtvec_i, if_id_flush_o=1, id_ex_flush_o=1. Then go to FLUSH (FLUSH_CYCLES>1) or RUN, and trap_req_o falls.
  - ex_jump_i, ex_busy_i and id inputs are ignored in TRAP; EX is empty by construction.
- Whenever pc_jump_o=0, pc_jump_addr_o=0.
- stall_cnt_o increments on every cycle with pc_hold_o | if_id_flush_o. It saturates at all-ones. stall_cnt_clr_i clears it and wins over increment.

## Timing
- Asynchronous reset sets: state=RUN, count=0, trap_req_o=0, trap_pc_o=0, stall_cnt_o=0.
- While rst_n=0, every combinational output is 0.
- Hold, flush and jump outputs are combinational from the current state and inputs, valid in the same cycle, and consumed at the next rising edge.
- trap_req_o and trap_pc_o are registered: they rise the cycle after error detection and fall the cycle after the ack edge.
- trap_ack_i is only sampled while trap_req_o=1.
- Redirect cost: FLUSH_CYCLES bubble cycles, counting the jump cycle.
- A load-use hazard costs exactly one bubble.
- Reset asserted mid-FLUSH or mid-TRAP aborts to RUN with no request left pending.

## Test plan
- Load-use: EX load rd=5, ID add with rs2=5 -> one cycle of pc_hold_o=if_id_hold_o=id_ex_flush_o=1, then clear. With rd=0, no stall.
- Jump with FLUSH_CYCLES=3, target 0x80 -> pc_jump_o=1 with addr 0x80 for one cycle; if_id_flush_o high for 3 cycles; stall_cnt_o=3.
- Busy plus hazard: ex_busy_i high for 4 cycles while a hazard is present -> 4 cycles of all holds, then 1 load-use bubble.
- Trap: id_err_i with id_pc_i=0x40, ack after 2 cycles, mtvec_i=0x100 -> trap_pc_o=0x40 and trap_req_o high for 2 cycles. The ack cycle gives pc_jump_o=1 with addr 0x100.
- Priority: ex_jump_i together with id_err_i -> jump taken, no trap_req_o.
- Counter: preload near saturation with CNT_WIDTH=4 -> holds at 0xF. stall_cnt_clr_i during a stall gives 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: hold/flush/redirect generation for PC, IF-ID
// and ID-EX, illegal-instruction trap handshake, and a saturating lost-cycle counter.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid_i,
  input  logic [31:0]          id_pc_i,
  input  logic [6:0]           id_opcode_i,
  input  logic [2:0]           id_funct3_i,
  input  logic [4:0]           id_rs1_addr_i,
  input  logic [4:0]           id_rs2_addr_i,
  input  logic                 id_err_i,
  input  logic                 ex_is_load_i,
  input  logic [4:0]           ex_rd_addr_i,
  input  logic                 ex_jump_i,
  input  logic [31:0]          ex_jump_addr_i,
  input  logic                 ex_busy_i,
  input  logic [31:0]          mtvec_i,
  input  logic                 trap_ack_i,
  output logic                 pc_hold_o,
  output logic                 if_id_hold_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_hold_o,
  output logic                 id_ex_flush_o,
  output logic                 pc_jump_o,
  output logic [31:0]          pc_jump_addr_o,
  output logic                 trap_req_o,
  output logic [31:0]          trap_pc_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  input  logic                 stall_cnt_clr_i
);

  typedef enum logic [1:0] {RUN, FLUSH, TRAP} state_t;

  localparam bit         USE_FLUSH  = (FLUSH_CYCLES > 1);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state, next_state;
  logic [2:0]  count, next_count;

  logic        rs1_used, rs2_used, hazard;
  logic        take_trap, ack_taken;
  logic        c_pc_hold, c_if_id_hold, c_if_id_flush;
  logic        c_id_ex_hold, c_id_ex_flush, c_pc_jump;
  logic [31:0] c_jump_addr;

  // SYSTEM only reads rs1 for the register forms (funct3 = 0xx).
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (id_opcode_i)
      7'b0010011, 7'b0000011, 7'b1100111: rs1_used = 1'b1;
      7'b0100011, 7'b0110011, 7'b1100011: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      7'b1110011: rs1_used = id_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b011};
      default: ;
    endcase
  end

  assign hazard = id_valid_i & ex_is_load_i & (ex_rd_addr_i != 5'd0) &
                  ((rs1_used & (id_rs1_addr_i == ex_rd_addr_i)) |
                   (rs2_used & (id_rs2_addr_i == ex_rd_addr_i)));

  always_comb begin
    c_pc_hold     = 1'b0;
    c_if_id_hold  = 1'b0;
    c_if_id_flush = 1'b0;
    c_id_ex_hold  = 1'b0;
    c_id_ex_flush = 1'b0;
    c_pc_jump     = 1'b0;
    c_jump_addr   = 32'd0;
    take_trap     = 1'b0;
    ack_taken     = 1'b0;
    next_state    = state;
    next_count    = count;
    case (state)
      RUN, FLUSH: begin
        if (ex_jump_i) begin
          c_pc_jump     = 1'b1;
          c_jump_addr   = ex_jump_addr_i;
          c_if_id_flush = 1'b1;
          c_id_ex_flush = 1'b1;
          next_state    = USE_FLUSH ? FLUSH : RUN;
          next_count    = USE_FLUSH ? FLUSH_LOAD : 3'd0;
        end else if (state == FLUSH) begin
          c_if_id_flush = 1'b1;
          c_id_ex_flush = 1'b1;
          next_count    = count - 3'd1;
          if (count <= 3'd1) next_state = RUN;
        end else if (ex_busy_i) begin
          c_pc_hold    = 1'b1;
          c_if_id_hold = 1'b1;
          c_id_ex_hold = 1'b1;
        end else if (id_valid_i & id_err_i) begin
          c_pc_hold     = 1'b1;
          c_if_id_hold  = 1'b1;
          c_id_ex_flush = 1'b1;
          take_trap     = 1'b1;
          next_state    = TRAP;
        end else if (hazard) begin
          c_pc_hold     = 1'b1;
          c_if_id_hold  = 1'b1;
          c_id_ex_flush = 1'b1;
        end
      end
      TRAP: begin
        if (trap_req_o & trap_ack_i) begin
          c_pc_jump     = 1'b1;
          c_jump_addr   = mtvec_i;
          c_if_id_flush = 1'b1;
          c_id_ex_flush = 1'b1;
          ack_taken     = 1'b1;
          next_state    = USE_FLUSH ? FLUSH : RUN;
          next_count    = USE_FLUSH ? FLUSH_LOAD : 3'd0;
        end else begin
          c_pc_hold     = 1'b1;
          c_if_id_hold  = 1'b1;
          c_id_ex_flush = 1'b1;
        end
      end
      default: begin
        next_state = RUN;
        next_count = 3'd0;
      end
    endcase
  end

  // Controls are forced low while reset is asserted.
  assign pc_hold_o      = rst_n & c_pc_hold;
  assign if_id_hold_o   = rst_n & c_if_id_hold;
  assign if_id_flush_o  = rst_n & c_if_id_flush;
  assign id_ex_hold_o   = rst_n & c_id_ex_hold;
  assign id_ex_flush_o  = rst_n & c_id_ex_flush;
  assign pc_jump_o      = rst_n & c_pc_jump;
  assign pc_jump_addr_o = rst_n ? c_jump_addr : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      count      <= 3'd0;
      trap_req_o <= 1'b0;
      trap_pc_o  <= 32'd0;
    end else begin
      state <= next_state;
      count <= next_count;
      if (take_trap) begin
        trap_req_o <= 1'b1;
        trap_pc_o  <= id_pc_i;
      end else if (ack_taken) begin
        trap_req_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_o <= '0;
    else if (stall_cnt_clr_i)
      stall_cnt_o <= '0;
    else if ((pc_hold_o | if_id_flush_o) && (stall_cnt_o != {CNT_WIDTH{1'b1}}))
      stall_cnt_o <= stall_cnt_o + 1'b1;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each cycle's expected control/status vector is queued
// by the driver and checked by an independent negedge monitor.
module tb_pipe_ctrl;

  localparam int CW = 4;
  localparam int W  = 6 + 32 + 1 + 32 + CW;

  logic          clk;
  logic          rst_n;
  logic          id_valid_i;
  logic [31:0]   id_pc_i;
  logic [6:0]    id_opcode_i;
  logic [2:0]    id_funct3_i;
  logic [4:0]    id_rs1_addr_i, id_rs2_addr_i;
  logic          id_err_i;
  logic          ex_is_load_i;
  logic [4:0]    ex_rd_addr_i;
  logic          ex_jump_i;
  logic [31:0]   ex_jump_addr_i;
  logic          ex_busy_i;
  logic [31:0]   mtvec_i;
  logic          trap_ack_i;
  logic          pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_hold_o, id_ex_flush_o, pc_jump_o;
  logic [31:0]   pc_jump_addr_o;
  logic          trap_req_o;
  logic [31:0]   trap_pc_o;
  logic [CW-1:0] stall_cnt_o;
  logic          stall_cnt_clr_i;

  pipe_ctrl #(.FLUSH_CYCLES(3), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_opcode_i(id_opcode_i),
    .id_funct3_i(id_funct3_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_err_i(id_err_i), .ex_is_load_i(ex_is_load_i), .ex_rd_addr_i(ex_rd_addr_i),
    .ex_jump_i(ex_jump_i), .ex_jump_addr_i(ex_jump_addr_i), .ex_busy_i(ex_busy_i),
    .mtvec_i(mtvec_i), .trap_ack_i(trap_ack_i),
    .pc_hold_o(pc_hold_o), .if_id_hold_o(if_id_hold_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_hold_o(id_ex_hold_o), .id_ex_flush_o(id_ex_flush_o), .pc_jump_o(pc_jump_o),
    .pc_jump_addr_o(pc_jump_addr_o), .trap_req_o(trap_req_o), .trap_pc_o(trap_pc_o),
    .stall_cnt_o(stall_cnt_o), .stall_cnt_clr_i(stall_cnt_clr_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b1;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  // ctrl = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, pc_jump}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_BUBL  = 6'b110010;
  localparam logic [5:0] C_BUSY  = 6'b110100;
  localparam logic [5:0] C_JUMP  = 6'b001011;
  localparam logic [5:0] C_FLUSH = 6'b001010;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v, act_v;
      string        nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_hold_o, id_ex_flush_o,
               pc_jump_o, pc_jump_addr_o, trap_req_o, trap_pc_o, stall_cnt_o};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got ctrl=%b addr=%h req=%b tpc=%h cnt=%h, want ctrl=%b addr=%h req=%b tpc=%h cnt=%h",
                 nm, act_v[W-1 -: 6], act_v[W-7 -: 32], act_v[CW+32], act_v[CW+31 -: 32], act_v[CW-1:0],
                 exp_v[W-1 -: 6], exp_v[W-7 -: 32], exp_v[CW+32], exp_v[CW+31 -: 32], exp_v[CW-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_valid_i = 0; id_pc_i = 0; id_opcode_i = 0; id_funct3_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_err_i = 0;
    ex_is_load_i = 0; ex_rd_addr_i = 0; ex_jump_i = 0; ex_jump_addr_i = 0;
    ex_busy_i = 0; mtvec_i = 0; trap_ack_i = 0; stall_cnt_clr_i = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [6:0] op, input logic [2:0] f3,
                              input logic [4:0] rs1, input logic [4:0] rs2);
    ex_is_load_i = 1; ex_rd_addr_i = rd;
    id_valid_i = 1; id_opcode_i = op; id_funct3_i = f3;
    id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
  endtask

  // Queue the expectation for the current cycle, then advance past the next edge.
  task automatic step(input string nm, input logic [5:0] ctrl, input logic [31:0] addr,
                      input logic req, input logic [31:0] tpc, input logic [CW-1:0] cnt);
    exp_q.push_back({ctrl, addr, req, tpc, cnt});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    rst_n = 0;
    ex_jump_i = 1; ex_jump_addr_i = 32'h1234; id_valid_i = 1; id_err_i = 1;
    step("reset_comb0", C_NONE, 0, 0, 0, 0);
    step("reset_comb1", C_NONE, 0, 0, 0, 0);
    rst_n = 1;
    set_idle();
    step("idle", C_NONE, 0, 0, 0, 0);

    // load-use on rs2, then cleared
    set_load_use(5'd5, 7'b0110011, 3'b000, 5'd1, 5'd5);
    step("lu_rs2", C_BUBL, 0, 0, 0, 0);
    ex_is_load_i = 0;
    step("lu_clear", C_NONE, 0, 0, 0, 1);
    set_load_use(5'd0, 7'b0110011, 3'b000, 5'd0, 5'd0);
    step("lu_rd0", C_NONE, 0, 0, 0, 1);
    set_load_use(5'd5, 7'b0010011, 3'b000, 5'd1, 5'd5);
    step("lu_rs2_unused", C_NONE, 0, 0, 0, 1);
    set_load_use(5'd5, 7'b1110011, 3'b101, 5'd5, 5'd0);
    step("lu_csr_imm", C_NONE, 0, 0, 0, 1);
    set_load_use(5'd5, 7'b1110011, 3'b001, 5'd5, 5'd0);
    step("lu_csr_reg", C_BUBL, 0, 0, 0, 1);
    set_idle(); stall_cnt_clr_i = 1;
    step("clr_idle", C_NONE, 0, 0, 0, 2);
    set_idle();

    // jump beats a simultaneous decode error; FLUSH_CYCLES=3 bubbles
    ex_jump_i = 1; ex_jump_addr_i = 32'h80; id_valid_i = 1; id_err_i = 1; id_pc_i = 32'h40;
    step("jump", C_JUMP, 32'h80, 0, 0, 0);
    set_idle();
    step("flush1", C_FLUSH, 0, 0, 0, 1);
    step("flush2", C_FLUSH, 0, 0, 0, 2);
    step("after_flush", C_NONE, 0, 0, 0, 3);

    // jump arriving mid-FLUSH restarts the redirect
    ex_jump_i = 1; ex_jump_addr_i = 32'h200;
    step("jump_a", C_JUMP, 32'h200, 0, 0, 3);
    ex_jump_addr_i = 32'h300;
    step("jump_in_flush", C_JUMP, 32'h300, 0, 0, 4);
    set_idle();
    step("reflush1", C_FLUSH, 0, 0, 0, 5);
    step("reflush2", C_FLUSH, 0, 0, 0, 6);
    stall_cnt_clr_i = 1;
    step("reflush_done", C_NONE, 0, 0, 0, 7);
    set_idle();

    // busy over a pending hazard: 4 full holds, then one load-use bubble
    set_load_use(5'd5, 7'b0110011, 3'b000, 5'd1, 5'd5);
    ex_busy_i = 1;
    for (int i = 0; i < 4; i++) step("busy_hold", C_BUSY, 0, 0, 0, CW'(i));
    ex_busy_i = 0;
    step("busy_then_bubble", C_BUBL, 0, 0, 0, 4);
    ex_is_load_i = 0; stall_cnt_clr_i = 1;
    step("busy_done", C_NONE, 0, 0, 0, 5);
    set_idle();

    // trap: error waits behind busy, request held two cycles, ack redirects to mtvec
    id_valid_i = 1; id_err_i = 1; id_pc_i = 32'h40; ex_busy_i = 1;
    step("err_busy", C_BUSY, 0, 0, 0, 0);
    ex_busy_i = 0;
    step("err_detect", C_BUBL, 0, 0, 0, 1);
    set_idle(); ex_jump_i = 1; ex_jump_addr_i = 32'h999; ex_busy_i = 1; id_pc_i = 32'h77;
    step("trap_wait", C_BUBL, 0, 1, 32'h40, 2);
    set_idle(); trap_ack_i = 1; mtvec_i = 32'h100;
    step("trap_ack", C_JUMP, 32'h100, 1, 32'h40, 3);
    set_idle();
    step("trap_flush1", C_FLUSH, 0, 0, 32'h40, 4);
    step("trap_flush2", C_FLUSH, 0, 0, 32'h40, 5);
    step("trap_done", C_NONE, 0, 0, 32'h40, 6);

    // saturation at 0xF, then clear during a stall
    set_load_use(5'd7, 7'b0000011, 3'b010, 5'd7, 5'd0);
    for (int i = 0; i < 12; i++) step("sat", C_BUBL, 0, 0, 32'h40, (6 + i > 15) ? 4'hF : CW'(6 + i));
    stall_cnt_clr_i = 1;
    step("clr_in_stall", C_BUBL, 0, 0, 32'h40, 4'hF);
    set_idle();
    step("after_clr", C_NONE, 0, 0, 32'h40, 0);

    // reset asserted mid-TRAP aborts with no request pending
    id_valid_i = 1; id_err_i = 1; id_pc_i = 32'h44;
    step("err2", C_BUBL, 0, 0, 32'h40, 0);
    set_idle(); rst_n = 0;
    step("reset_in_trap", C_NONE, 0, 0, 0, 0);
    rst_n = 1;
    step("post_reset", C_NONE, 0, 0, 0, 0);

    // bounded drain of the scoreboard
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
